// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between instruction fetch (IF)
//             and data memory (DM). DM has priority, IF has a starvation guard,
//             and a hung memory access is aborted after a timeout.
//  Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] c_TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [31:0]   c_ERR_DATA   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_dm_q, owner_dm_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          dm_valid_q, dm_valid_d;
    logic          err_q, err_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          w_grant_dm;
    logic          w_starved;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_dm_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            err_q       <= 1'b0;
            starve_q    <= '0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_dm_q  <= owner_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_dm_d  = owner_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = err_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;

        // DM wins a collision until IF has been passed over STARVE_LIMIT times
        w_starved  = (starve_q == c_STARVE_MAX);
        w_grant_dm = dm_req & (~if_req | ~w_starved);

        unique case (state_q)
            S_IDLE: begin
                if (mem_ready) begin
                    err_d = 1'b1;
                end
                if (if_req | dm_req) begin
                    state_d    = S_BUSY;
                    owner_dm_d = w_grant_dm;
                    mem_req_d  = 1'b1;
                    tmo_d      = '0;
                    if (w_grant_dm) begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = {dm_addr[31:2], 2'b00};
                        mem_wdata_d = dm_wdata;
                        if (if_req && !w_starved) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {if_addr[31:2], 2'b00};
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ready || tmo_q == c_TMO_LAST) begin
                    state_d    = S_RESP;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_valid_d = owner_dm_q;
                    if_valid_d = ~owner_dm_q;
                    if (!mem_ready) begin
                        err_d = 1'b1;
                    end
                    if (owner_dm_q) begin
                        dm_rdata_d = mem_ready ? mem_rdata : c_ERR_DATA;
                    end else begin
                        if_rdata_d = mem_ready ? mem_rdata : c_ERR_DATA;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RESP: begin
                if (mem_ready) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign if_stall  = if_req & ~if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign dm_stall  = dm_req & ~dm_valid_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: transaction-level reference model compared every
// cycle, random traffic, and directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 3;
    localparam int TIMEOUT      = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one outstanding transaction record plus a response pulse.
    bit          m_busy, m_own_dm, m_we;
    int          m_age, m_starve;
    logic [31:0] m_addr, m_wdata, m_d;
    logic [31:0] e_if_rdata, e_dm_rdata;
    bit          e_if_valid, e_dm_valid, e_err;
    bit          grant_log[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_own_dm = 0; m_we = 0; m_age = 0; m_starve = 0;
            m_addr = '0; m_wdata = '0;
            e_if_rdata = '0; e_dm_rdata = '0;
            e_if_valid = 0; e_dm_valid = 0; e_err = 0;
        end else if (m_busy) begin
            m_age++;
            if (mem_ready || m_age == TIMEOUT) begin
                m_d = mem_ready ? mem_rdata : 32'hDEAD_BEEF;
                if (!mem_ready) e_err = 1;
                if (m_own_dm) begin e_dm_rdata = m_d; e_dm_valid = 1; end
                else          begin e_if_rdata = m_d; e_if_valid = 1; end
                m_busy = 0;
            end
        end else if (e_if_valid || e_dm_valid) begin
            if (mem_ready) e_err = 1;
            e_if_valid = 0;
            e_dm_valid = 0;
        end else begin
            if (mem_ready) e_err = 1;
            if (if_req || dm_req) begin
                m_own_dm = dm_req && !(if_req && m_starve == STARVE_LIMIT);
                grant_log.push_back(m_own_dm);
                if (m_own_dm) begin
                    m_we = dm_we; m_addr = dm_addr & ~32'h3; m_wdata = dm_wdata;
                    if (if_req && m_starve < STARVE_LIMIT) m_starve++;
                end else begin
                    m_we = 0; m_addr = if_addr & ~32'h3; m_starve = 0;
                end
                m_busy = 1;
                m_age  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("mem_req", 32'(mem_req), 32'(m_busy));
            if (m_busy) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", 32'(mem_we), 32'(m_we));
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("if_valid", 32'(if_valid), 32'(e_if_valid));
            chk("dm_valid", 32'(dm_valid), 32'(e_dm_valid));
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("dm_rdata", dm_rdata, e_dm_rdata);
            chk("err", 32'(err), 32'(e_err));
            chk("if_stall", 32'(if_stall), 32'(if_req & ~e_if_valid));
            chk("dm_stall", 32'(dm_stall), 32'(dm_req & ~e_dm_valid));
        end
    end

    // Memory responder: 0 = random latency, 1 = never ready, 2 = zero wait, 3 = manual
    int          resp_mode = 2;
    logic [31:0] mem_arr [0:255];

    always @(negedge clk) begin
        #1;
        if (resp_mode != 3) begin
            mem_ready = 1'b0;
            if (mem_req && !reset &&
                (resp_mode == 2 || (resp_mode == 0 && $urandom_range(0, 2) == 0))) begin
                mem_ready = 1'b1;
                if (mem_we) mem_arr[mem_addr[9:2]] = mem_wdata;
                mem_rdata = mem_arr[mem_addr[9:2]];
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
    endtask

    task automatic wait_valid(input bit dm, input string name);
        int n = 0;
        while (!(dm ? dm_valid : if_valid) && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (n < 40) n_pass++;
        else $display("FAIL %s: no valid pulse after %0d cycles, required within 40", name, n);
    endtask

    int  n, hi;
    bit  prev;
    bit  dut_log[$];
    bit  exp_pat [0:4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        repeat (2) step();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_valids", {30'b0, if_valid, dm_valid}, 0);
        reset = 1'b0;
        step();

        // Single fetch with zero-wait memory
        resp_mode = 2;
        mem_arr[1] = 32'h2008_0005;
        if_req = 1'b1; if_addr = 32'h0040_0004;
        #1 chk("fetch_stall_n", 32'(if_stall), 1);
        step();
        chk("fetch_mem_req", 32'(mem_req), 1);
        chk("fetch_mem_addr", mem_addr, 32'h0040_0004);
        chk("fetch_stall_n1", 32'(if_stall), 1);
        step();
        chk("fetch_valid", 32'(if_valid), 1);
        chk("fetch_rdata", if_rdata, 32'h2008_0005);
        chk("fetch_stall_n2", 32'(if_stall), 0);
        if_req = 1'b0;
        step();
        chk("fetch_valid_once", 32'(if_valid), 0);

        // Store then load to the same word
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0003; dm_wdata = 32'hCAFE_F00D;
        step();
        chk("store_we", 32'(mem_we), 1);
        chk("store_addr", mem_addr, 32'h1001_0000);
        chk("store_wdata", mem_wdata, 32'hCAFE_F00D);
        wait_valid(1, "store_wait");
        dm_req = 1'b0; dm_we = 1'b0;
        step();
        dm_req = 1'b1;
        step();
        chk("load_we", 32'(mem_we), 0);
        wait_valid(1, "load_wait");
        chk("load_rdata", dm_rdata, 32'hCAFE_F00D);
        dm_req = 1'b0;
        step();

        // Collision: grant order must be DM, DM, DM, IF, DM
        grant_log.delete();
        if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0;
        if_req = 1'b1; dm_req = 1'b1;
        n = 0; prev = 0;
        while (dut_log.size() < 5 && n < 60) begin
            step();
            if (mem_req && !prev) dut_log.push_back(mem_addr == 32'h200);
            prev = mem_req;
            n++;
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk("starve_grants", dut_log.size(), 5);
        for (int i = 0; i < dut_log.size() && i < 5; i++) begin
            chk("starve_order_dut", 32'(dut_log[i]), 32'(exp_pat[i]));
            if (i < grant_log.size()) chk("starve_order_model", 32'(grant_log[i]), 32'(exp_pat[i]));
        end
        repeat (4) step();

        // Random traffic against the model
        resp_mode = 0;
        for (int c = 0; c < 1500; c++) begin
            if (if_req) begin
                if (if_valid) begin if_req = 1'($urandom_range(0, 1)); if_addr = $urandom; end
                else if ($urandom_range(0, 31) == 0) if_req = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (dm_req) begin
                if (dm_valid) begin
                    dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
                    dm_addr = $urandom; dm_wdata = $urandom;
                end else if ($urandom_range(0, 31) == 0) dm_req = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = $urandom; dm_wdata = $urandom;
            end
            step();
        end
        if_req = 1'b0; dm_req = 1'b0;
        repeat (25) step();

        // Reset during the second wait cycle of a fetch
        resp_mode = 1;
        do_reset();
        if_req = 1'b1; if_addr = 32'h0040_0010;
        step();
        chk("rstbusy_mem_req", 32'(mem_req), 1);
        step();
        reset = 1'b1;
        #1 chk("rstbusy_async_drop", 32'(mem_req), 0);
        if_req = 1'b0;
        step();
        chk("rstbusy_no_valid", 32'(if_valid), 0);
        step();
        reset = 1'b0;
        step();
        chk("rstbusy_idle_valid", 32'(if_valid), 0);
        chk("rstbusy_idle_req", 32'(mem_req), 0);
        resp_mode = 2;
        if_req = 1'b1;
        step();
        chk("rstbusy_regrant", 32'(mem_req), 1);
        wait_valid(0, "rstbusy_wait");
        if_req = 1'b0;
        step();

        // Spurious mem_ready while idle
        mem_arr[5] = 32'h1357_2468;
        if_req = 1'b1; if_addr = 32'h14;
        step();
        wait_valid(0, "spur_fetch_wait");
        chk("spur_pre_rdata", if_rdata, 32'h1357_2468);
        if_req = 1'b0;
        step();
        chk("spur_pre_err", 32'(err), 0);
        resp_mode = 3;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        mem_ready = 1'b0;
        chk("spur_err", 32'(err), 1);
        chk("spur_no_valid", {30'b0, if_valid, dm_valid}, 0);
        chk("spur_if_rdata", if_rdata, 32'h1357_2468);
        chk("spur_dm_rdata", dm_rdata, 0);
        step();
        chk("spur_if_rdata_hold", if_rdata, 32'h1357_2468);

        // Timeout on a hung load
        resp_mode = 1;
        do_reset();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        step();
        hi = 0;
        while (mem_req && hi < 40) begin
            hi++;
            step();
        end
        chk("tmo_busy_cycles", hi, 16);
        chk("tmo_valid", 32'(dm_valid), 1);
        chk("tmo_rdata", dm_rdata, 32'hDEAD_BEEF);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_if_valid", 32'(if_valid), 0);
        dm_req = 1'b0;
        step();
        resp_mode = 2;
        if_req = 1'b1; if_addr = 32'h8;
        step();
        wait_valid(0, "tmo_after_wait");
        if_req = 1'b0;
        step();
        chk("tmo_err_sticky", 32'(err), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
